// File: rtl/exc_ctrl_pkg.sv
// Shared types for the exception/interrupt commit sequencer: FSM states,
// exception vector bit indices, CSR cause codes and small decode helpers.
package exc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRAP     = 3'd1,
        ST_ERET     = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_DRAIN    = 3'd4
    } exc_state_t;

    localparam int VEC_ADEF = 0;
    localparam int VEC_TLBR = 1;
    localparam int VEC_PIF  = 2;
    localparam int VEC_PPI  = 3;
    localparam int VEC_INE  = 4;
    localparam int VEC_IPE  = 5;
    localparam int VEC_FPD  = 6;
    localparam int VEC_SYS  = 7;
    localparam int VEC_BRK  = 8;
    localparam int VEC_FPE  = 9;
    localparam int VEC_ALE  = 10;
    localparam int VEC_ADEM = 11;
    localparam int VEC_PIL  = 12;
    localparam int VEC_PIS  = 13;
    localparam int VEC_PME  = 14;
    localparam int VEC_NUM  = 15;

    localparam logic [5:0] CAUSE_INT  = 6'h00;
    localparam logic [5:0] CAUSE_PIL  = 6'h01;
    localparam logic [5:0] CAUSE_PIS  = 6'h02;
    localparam logic [5:0] CAUSE_PIF  = 6'h03;
    localparam logic [5:0] CAUSE_PME  = 6'h04;
    localparam logic [5:0] CAUSE_PPI  = 6'h07;
    localparam logic [5:0] CAUSE_ADE  = 6'h08;
    localparam logic [5:0] CAUSE_ALE  = 6'h09;
    localparam logic [5:0] CAUSE_SYS  = 6'h0b;
    localparam logic [5:0] CAUSE_BRK  = 6'h0c;
    localparam logic [5:0] CAUSE_INE  = 6'h0d;
    localparam logic [5:0] CAUSE_IPE  = 6'h0e;
    localparam logic [5:0] CAUSE_FPD  = 6'h0f;
    localparam logic [5:0] CAUSE_FPE  = 6'h12;
    localparam logic [5:0] CAUSE_TLBR = 6'h3f;

    function automatic logic [5:0] vec_bit_cause(input int idx);
        logic [5:0] c;
        c = CAUSE_INE;
        case (idx)
            VEC_ADEF: c = CAUSE_ADE;
            VEC_TLBR: c = CAUSE_TLBR;
            VEC_PIF:  c = CAUSE_PIF;
            VEC_PPI:  c = CAUSE_PPI;
            VEC_INE:  c = CAUSE_INE;
            VEC_IPE:  c = CAUSE_IPE;
            VEC_FPD:  c = CAUSE_FPD;
            VEC_SYS:  c = CAUSE_SYS;
            VEC_BRK:  c = CAUSE_BRK;
            VEC_FPE:  c = CAUSE_FPE;
            VEC_ALE:  c = CAUSE_ALE;
            VEC_ADEM: c = CAUSE_ADE;
            VEC_PIL:  c = CAUSE_PIL;
            VEC_PIS:  c = CAUSE_PIS;
            VEC_PME:  c = CAUSE_PME;
            default:  c = CAUSE_INE;
        endcase
        return c;
    endfunction

    // Causes whose handler needs the faulting data address in BADV.
    function automatic logic cause_has_badaddr(input logic [5:0] c);
        return (c == CAUSE_TLBR) || (c == CAUSE_ALE) || (c == CAUSE_PIL) ||
               (c == CAUSE_PIS)  || (c == CAUSE_PIF) || (c == CAUSE_PME) ||
               (c == CAUSE_PPI);
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Commit-stage handshake bundle between the pipeline (master) and exc_ctrl (slave).
interface exc_ctrl_if #(parameter int EXC_VEC_W = 16);
    logic                 commit_valid;
    logic                 commit_ready;
    logic [31:0]          commit_pc;
    logic [EXC_VEC_W-1:0] commit_exc_vec;
    logic [31:0]          commit_badaddr;
    logic                 commit_is_ertn;

    modport master (
        output commit_valid, commit_pc, commit_exc_vec, commit_badaddr, commit_is_ertn,
        input  commit_ready
    );

    modport slave (
        input  commit_valid, commit_pc, commit_exc_vec, commit_badaddr, commit_is_ertn,
        output commit_ready
    );
endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// Fixed-priority cause encoder: a pending interrupt wins, then the lowest set vector bit.
import exc_ctrl_pkg::*;

module exc_prio_enc #(
    parameter int EXC_VEC_W = 16
) (
    input  logic [EXC_VEC_W-1:0] exc_vec,
    input  logic                 int_pend,
    output logic                 exc_any,
    output logic [5:0]           cause
);
    always_comb begin
        exc_any = 1'b0;
        cause   = CAUSE_INT;
        // Reserved bits at and above VEC_NUM carry no cause and are ignored.
        for (int i = EXC_VEC_W - 1; i >= 0; i--) begin
            if (i < VEC_NUM && exc_vec[i]) begin
                exc_any = 1'b1;
                cause   = vec_bit_cause(i);
            end
        end
        if (int_pend) begin
            cause = CAUSE_INT;
        end
    end
endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt commit sequencer: strobes the CSR, then flushes and redirects fetch.
// Optional performance counters enabled by defining EXC_CTRL_PERF_CNT_EN.
import exc_ctrl_pkg::*;

module exc_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int EXC_VEC_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    exc_ctrl_if.slave   cmt,
    input  logic [11:0] ECFG_LIE,
    input  logic [11:0] ESTAT_IS,
    input  logic        CRMD_IE,
    input  logic [31:0] EENTRY_VA,
    input  logic [31:0] ERA_PC,
    input  logic [31:0] TLBRENTRY_VA,
    output logic        is_exception,
    output logic [5:0]  exception_cause,
    output logic [31:0] exception_pc,
    output logic [31:0] exception_addr,
    output logic        is_syscall_break,
    output logic        is_ertn,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef EXC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] exc_cnt,
    output logic [31:0] int_cnt
`endif
);
    exc_state_t  state;
    logic [3:0]  cnt;
    logic [5:0]  cause_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic        sysbrk_q;
    logic        ertn_q;

    logic        int_pend;
    logic        exc_any;
    logic [5:0]  enc_cause;
    logic        trap_req;
    logic        accept;

    assign int_pend = CRMD_IE & (|(ECFG_LIE & ESTAT_IS));
    assign trap_req = int_pend | exc_any;
    assign accept   = (state == ST_IDLE) & cmt.commit_valid & (trap_req | cmt.commit_is_ertn);

    exc_prio_enc #(.EXC_VEC_W(EXC_VEC_W)) u_prio_enc (
        .exc_vec  (cmt.commit_exc_vec),
        .int_pend (int_pend),
        .exc_any  (exc_any),
        .cause    (enc_cause)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= ST_IDLE;
            cnt              <= 4'd0;
            cause_q          <= 6'd0;
            pc_q             <= 32'd0;
            addr_q           <= 32'd0;
            sysbrk_q         <= 1'b0;
            ertn_q           <= 1'b0;
            cmt.commit_ready <= 1'b1;
            is_exception     <= 1'b0;
            is_ertn          <= 1'b0;
            flush            <= 1'b0;
            redirect_valid   <= 1'b0;
        end else begin
            is_exception   <= 1'b0;
            is_ertn        <= 1'b0;
            redirect_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmt.commit_ready <= 1'b0;
                        flush            <= 1'b1;
                        pc_q             <= cmt.commit_pc;
                        if (trap_req) begin
                            state        <= ST_TRAP;
                            is_exception <= 1'b1;
                            ertn_q       <= 1'b0;
                            cause_q      <= enc_cause;
                            addr_q       <= cause_has_badaddr(enc_cause) ? cmt.commit_badaddr : 32'd0;
                            sysbrk_q     <= (enc_cause == CAUSE_SYS) || (enc_cause == CAUSE_BRK);
                        end else begin
                            state    <= ST_ERET;
                            is_ertn  <= 1'b1;
                            ertn_q   <= 1'b1;
                            cause_q  <= 6'd0;
                            addr_q   <= 32'd0;
                            sysbrk_q <= 1'b0;
                        end
                    end
                end
                ST_TRAP, ST_ERET: begin
                    state          <= ST_REDIRECT;
                    redirect_valid <= 1'b1;
                end
                ST_REDIRECT: begin
                    state <= ST_DRAIN;
                    cnt   <= 4'(FLUSH_CYCLES - 1);
                end
                ST_DRAIN: begin
                    if (cnt == 4'd0) begin
                        state            <= ST_IDLE;
                        flush            <= 1'b0;
                        cmt.commit_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign exception_cause  = is_exception ? cause_q  : 6'd0;
    assign exception_pc     = is_exception ? pc_q     : 32'd0;
    assign exception_addr   = is_exception ? addr_q   : 32'd0;
    assign is_syscall_break = is_exception & sysbrk_q;

    // Target CSRs are read live in REDIRECT so the prior cycle's CSR write is seen.
    always_comb begin
        redirect_pc = 32'd0;
        if (state == ST_REDIRECT) begin
            if (ertn_q)                     redirect_pc = ERA_PC;
            else if (cause_q == CAUSE_TLBR) redirect_pc = TLBRENTRY_VA;
            else                            redirect_pc = EENTRY_VA;
        end
    end

`ifdef EXC_CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            exc_cnt <= 32'd0;
            int_cnt <= 32'd0;
        end else if (accept && trap_req) begin
            if (enc_cause == CAUSE_INT) int_cnt <= int_cnt + 32'd1;
            else                        exc_cnt <= exc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt commit sequencer for the CSR file.
- Takes the committing instruction's exception vector, its ertn flag and the CSR interrupt status.
- Selects one event by fixed priority and drives the CSR's one-cycle exception/ertn update strobes.
- Then flushes the pipeline and issues a single redirect to the handler entry or to ERA.

Parameters:
- FLUSH_CYCLES, 2, number of cycles spent in DRAIN after the redirect (1..15); 4-bit down counter.
- EXC_VEC_W, 16, width of the committed exception vector; bit 0 has highest priority.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- commit_valid  in  1  instruction presented at commit
- commit_ready  out  1  controller accepts commit (high only in IDLE)
- commit_pc  in  32  pc of the committing instruction
- commit_exc_vec  in  16  one-hot-or-more exception flags, priority order given in the package
- commit_badaddr  in  32  faulting data address
- commit_is_ertn  in  1  instruction is ertn
- ECFG_LIE  in  12  from csr
- ESTAT_IS  in  12  from csr
- CRMD_IE  in  1  from csr
- EENTRY_VA  in  32  from csr
- ERA_PC  in  32  from csr
- TLBRENTRY_VA  in  32  TLB-refill entry
- is_exception  out  1  csr strobe
- exception_cause  out  6  cause code, package encoding
- exception_pc  out  32  to csr
- exception_addr  out  32  to csr
- is_syscall_break  out  1  to csr
- is_ertn  out  1  csr strobe
- flush  out  1  pipeline flush
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target

Behaviour:
- Reset (rst==0 at a posedge): state=IDLE, counter=0. All outputs 0 except commit_ready=1.
- int_pend = CRMD_IE & |(ECFG_LIE & ESTAT_IS). This is combinational and evaluated only in IDLE.
- Accept when state==IDLE, commit_valid=1 and any of: int_pend, |commit_exc_vec, commit_is_ertn.
  - Plain commits with none of these pass through; the state stays IDLE.
- Priority on acceptance:
  - int_pend beats the exception vector; the lowest set vector bit beats higher bits; any exception beats ertn.
  - Interrupt: cause=INT, pc=commit_pc; the instruction is not executed.
  - When int_pend is high but commit_valid is low, the controller waits in IDLE.
- Latched on accept: cause, pc, badaddr, kind (EXC/ERTN), sysbrk = cause is SYS or BRK.
- FSM states: IDLE, TRAP, ERET, REDIRECT, DRAIN.
  - IDLE → TRAP on an accepted exception or interrupt.
  - IDLE → ERET on an accepted ertn.
  - TRAP → REDIRECT and ERET → REDIRECT unconditionally.
  - REDIRECT → DRAIN with counter=FLUSH_CYCLES-1.
  - DRAIN decrements the counter; DRAIN → IDLE when counter==0.
- Cycle timing for an accept at edge N:
  - N+1 (TRAP): is_exception=1 for exactly one cycle, with the latched cause, pc, addr and sysbrk.
  - N+1 (ERET instead): is_ertn=1 for exactly one cycle.
  - N+2 (REDIRECT): redirect_valid=1 for one cycle. redirect_pc = TLBRENTRY_VA if cause=TLBR, EENTRY_VA for other exceptions, ERA_PC for ertn.
  - ERA_PC and EENTRY_VA are sampled in REDIRECT, so the csr update from the previous cycle is visible.
- flush=1 in TRAP, ERET, REDIRECT and DRAIN; 0 in IDLE. commit_ready=0 whenever the state is not IDLE.
- exception_addr = badaddr for TLBR, ALE, PIL, PIS, PIF, PME and PPI; otherwise 0. The csr selects pc for ADEF.
- Inputs arriving while not IDLE are ignored; the pipeline holds them because commit_ready=0.
- Reset mid-sequence aborts immediately to IDLE, with no trailing strobe or redirect.

Optional Feature:
- Macro EXC_CTRL_PERF_CNT_EN.
- When defined, adds outputs exc_cnt[31:0] and int_cnt[31:0].
  - exc_cnt increments on TRAP entry for non-INT causes; int_cnt increments on TRAP entry for INT.
  - Both wrap at 2^32 and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state typedef;
  - exception vector bit indices: 0 ADEF, 1 TLBR, 2 PIF, 3 PPI, 4 INE, 5 IPE, 6 FPD, 7 SYS, 8 BRK, 9 FPE, 10 ALE, 11 ADEM, 12 PIL, 13 PIS, 14 PME, 15 reserved;
  - 6-bit cause codes: INT 0x0, PIL 0x1, PIS 0x2, PIF 0x3, PME 0x4, PPI 0x7, ADEF/ADEM 0x8, ALE 0x9, SYS 0xb, BRK 0xc, INE 0xd, IPE 0xe, FPD 0xf, FPE 0x12, TLBR 0x3f.
- One sub-module, exc_prio_enc: combinational priority encoder from vector plus int_pend to cause code.

Test Plan:
- Reset held low 3 cycles with commit_valid=1 and vec=0x0080 → all outputs 0, commit_ready=1, no strobe after release until a new commit.
- vec=0x0080 (SYS), pc=0x1c000100, EENTRY_VA=0x1c008000:
  - N+1: is_exception=1, cause=0x0b, is_syscall_break=1;
  - N+2: redirect_pc=0x1c008000;
  - flush high 2+FLUSH_CYCLES cycles.
- vec=0x0402 (ALE and TLBR), badaddr=0x00000fff → cause=0x3f, exception_addr=0x00000fff, redirect_pc=TLBRENTRY_VA.
- LIE=0x800, IS=0x800, IE=1, vec=0x0100, pc=0x1c000200 → cause=0x00 (interrupt wins), exception_pc=0x1c000200.
  - Repeat with IE=0 → cause=0x0c.
- commit_is_ertn=1, ERA_PC=0x1c000104 → is_ertn pulse at N+1, redirect_pc=0x1c000104 at N+2, is_exception stays 0.
- Accept a commit, then drive rst low at N+1 (TRAP) → next cycle IDLE, is_exception=0, no redirect_valid ever issued.
